// File: rtl/fib_index_pkg.sv
// fib_index_pkg
// Shared constants for the Fibonacci blocks: the one-hot FSM state
// encodings, the default operand width and the result index width.
// No ports; imported with "import fib_index_pkg::*;".
package fib_index_pkg;

    // Default operand width; legal range for W is 2..20.
    localparam int FIB_W_DEFAULT = 20;

    // Width of the Fibonacci index. With W <= 20 the index never exceeds 30.
    localparam int FIB_N_W = 5;

    // One-hot FSM encodings, kept as plain constants for legacy tools.
    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_OP   = 3'b010;
    localparam logic [2:0] ST_DONE = 3'b100;

    typedef logic [FIB_N_W-1:0] fib_n_t;

endpackage

// File: rtl/fib_index_if.sv
// fib_index_if
// Request/result bundle for fib_index.
//   start  : request, honoured only while ready is high
//   value  : W-bit operand, sampled on the accepting edge
//   ready  : block is idle and will accept start
//   done   : one-cycle pulse, n_out/exact valid
//   n_out  : largest n with F(n) <= value
//   exact  : F(n_out) == value
// master = requester side, slave = fib_index side.
interface fib_index_if #(
    parameter int W = 20
);
    import fib_index_pkg::*;

    logic           start;
    logic [W-1:0]   value;
    logic           ready;
    logic           done;
    fib_n_t         n_out;
    logic           exact;

    modport master (
        output start,
        output value,
        input  ready,
        input  done,
        input  n_out,
        input  exact
    );

    modport slave (
        input  start,
        input  value,
        output ready,
        output done,
        output n_out,
        output exact
    );

endinterface

// File: rtl/fib_index.sv
// fib_index
// Finds the largest n with F(n) <= value (F(0)=0, F(1)=1) by walking the
// Fibonacci sequence one term per cycle, and reports whether the value is
// itself a Fibonacci number.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, dominates start
//   bus  : fib_index_if.slave (start/value in, ready/done/n_out/exact out)
// Timing: start accepted at the end of cycle 0, n+1 OP cycles follow,
// done is high in cycle n+2 and ready returns in cycle n+3.
module fib_index
    import fib_index_pkg::*;
#(
    parameter int W = FIB_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    fib_index_if.slave  bus
);

    // t0/t1 carry one spare bit: the walk stops on the first t1 above the
    // operand, which can reach F(31) = 1346269 for a 20-bit operand.
    logic [2:0]   state_q, state_d;
    logic [W:0]   t0_q, t0_d;
    logic [W:0]   t1_q, t1_d;
    fib_n_t       k_q, k_d;
    logic [W-1:0] val_q, val_d;
    fib_n_t       n_out_q, n_out_d;
    logic         exact_q, exact_d;

    logic [W:0]   val_ext_s;

    assign val_ext_s = {1'b0, val_q};

    // Next-state and next-datapath logic for the whole block.
    always_comb begin
        state_d = state_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        k_d     = k_q;
        val_d   = val_q;
        n_out_d = n_out_q;
        exact_d = exact_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    val_d   = bus.value;
                    t0_d    = {(W+1){1'b0}};
                    t1_d    = {{W{1'b0}}, 1'b1};
                    k_d     = 5'd0;
                    state_d = ST_OP;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_OP: begin
                // t1 = F(k+1); once it passes the operand, F(k) is the answer.
                // value=0 exits on the first cycle since t1 starts at 1.
                if (t1_q > val_ext_s) begin
                    n_out_d = k_q;
                    exact_d = (t0_q == val_ext_s);
                    state_d = ST_DONE;
                end else begin
                    t0_d    = t1_q;
                    t1_d    = t0_q + t1_q;
                    k_d     = k_q + 5'd1;
                    state_d = ST_OP;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t0_q    <= {(W+1){1'b0}};
            t1_q    <= {(W+1){1'b0}};
            k_q     <= 5'd0;
            val_q   <= {W{1'b0}};
            n_out_q <= 5'd0;
            exact_q <= 1'b0;
        end else begin
            state_q <= state_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
            k_q     <= k_d;
            val_q   <= val_d;
            n_out_q <= n_out_d;
            exact_q <= exact_d;
        end
    end

    // Status strobes are straight decodes of the registered state.
    assign bus.ready = (state_q == ST_IDLE);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.n_out = n_out_q;
    assign bus.exact = exact_q;

endmodule

// File: tb/tb_fib_index.sv
// tb_fib_index
// Directed and random stimulus for fib_index. Expected results are pushed
// onto a scoreboard queue when a request is driven and popped when done
// pulses. Inputs change and outputs are sampled on the falling edge.
module tb_fib_index;
    import fib_index_pkg::*;

    localparam int W = 20;

    typedef struct {
        logic [4:0] n;
        logic       exact;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    longint fib_tab[32];

    fib_index_if #(.W(W)) bus ();

    fib_index #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: largest table index whose Fibonacci number fits in v.
    function automatic exp_t model(input logic [W-1:0] v);
        exp_t e;
        int   n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (fib_tab[i] <= longint'(v)) n = i;
        end
        e.n     = 5'(n);
        e.exact = (fib_tab[n] == longint'(v));
        e.lat   = n + 2;
        return e;
    endfunction

    // Called just after a falling edge in an idle cycle; returns just after
    // the falling edge of the cycle following done.
    task automatic run_op(input string name, input logic [W-1:0] v, input logic [4:0] n_exp,
                          input logic ex_exp, input int lat_exp, input bit hold,
                          input logic [W-1:0] v2);
        exp_t e;
        int   cnt;
        bit   seen;
        chk({name, "_ready_before"}, 32'(bus.ready), 32'd1);
        bus.start = 1'b1;
        bus.value = v;
        sb.push_back('{n: n_exp, exact: ex_exp, lat: lat_exp});
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 80) begin
            @(negedge clk);
            cnt++;
            if (hold) bus.value = v2;
            else      bus.start = 1'b0;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        e = sb.pop_front();
        chk({name, "_latency"}, 32'(cnt), 32'(e.lat));
        chk({name, "_n_out"}, 32'(bus.n_out), 32'(e.n));
        chk({name, "_exact"}, 32'(bus.exact), 32'(e.exact));
        @(negedge clk);
        chk({name, "_ready_after"}, 32'(bus.ready), 32'd1);
        chk({name, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        chk({name, "_n_out_hold"}, 32'(bus.n_out), 32'(e.n));
        chk({name, "_exact_hold"}, 32'(bus.exact), 32'(e.exact));
        bus.start = 1'b0;
        if (hold) begin
            @(negedge clk);
            chk({name, "_no_reaccept_ready"}, 32'(bus.ready), 32'd1);
            chk({name, "_no_reaccept_done"}, 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        exp_t        e;
        logic [W-1:0] rv;

        fib_tab[0] = 0;
        fib_tab[1] = 1;
        for (int i = 2; i < 32; i++) fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.value = '0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(bus.ready), 32'd1);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_n_out", 32'(bus.n_out), 32'd0);
        chk("reset_exact", 32'(bus.exact), 32'd0);

        // Start in the very first cycle after reset release.
        rst = 1'b0;
        run_op("v0", 20'd0, 5'd0, 1'b1, 2, 1'b0, 20'd0);
        @(negedge clk);
        run_op("v1", 20'd1, 5'd2, 1'b1, 4, 1'b0, 20'd0);
        @(negedge clk);
        run_op("v20", 20'd20, 5'd7, 1'b0, 9, 1'b0, 20'd0);
        @(negedge clk);
        run_op("hold20", 20'd20, 5'd7, 1'b0, 9, 1'b1, 20'd5);
        @(negedge clk);
        run_op("vmax", 20'd1048575, 5'd30, 1'b0, 32, 1'b0, 20'd0);
        @(negedge clk);
        run_op("v832040", 20'd832040, 5'd30, 1'b1, 32, 1'b0, 20'd0);

        // Reset three cycles into a long run.
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 20'd832040;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(bus.ready), 32'd1);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_n_out", 32'(bus.n_out), 32'd0);
        chk("midrst_exact", 32'(bus.exact), 32'd0);
        rst = 1'b0;
        run_op("v8_after_rst", 20'd8, 5'd6, 1'b1, 8, 1'b0, 20'd0);

        @(negedge clk);
        e = model(20'd4);
        run_op("v4", 20'd4, e.n, e.exact, e.lat, 1'b0, 20'd0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            rv = 20'($urandom_range(0, 1048575));
            e  = model(rv);
            run_op("rand", rv, e.n, e.exact, e.lat, 1'b0, 20'd0);
        end

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
